toy_seq_unlock: RTL and testbench

Parametrised successor to the single-pattern toy state machine used as a symbolic-fuzzing coverage target. It consumes a valid-qualified stream of data words and flags, and unlocks only after NUM_STAGES consecutive key words are matched with the required flag conditions. It adds a stall timeout, saturating hit/fail counters, a sticky error flag and a synchronous clear. It sits beside the existing demo DUTs as a deeper, harder-to-reach coverage target whose depth is tunable per experiment.

---
 rtl/toy_seq_unlock.sv | 168 ++++++++++++++++
 tb/tb_toy_seq_unlock.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/toy_seq_unlock.sv
// toy_seq_unlock: valid-qualified key-sequence matcher used as a deep coverage
// target. Unlocks after NUM_STAGES consecutive key words with the required
// flag conditions. Includes a stall timeout, saturating hit/fail counters,
// a sticky error flag and a synchronous clear.
module toy_seq_unlock #(
  parameter int                DATA_W     = 32,
  parameter int                FLAG_W     = 4,
  parameter int                NUM_STAGES = 4,
  parameter logic [DATA_W-1:0] KEY_BASE   = 'hAB,
  parameter int                TIMEOUT    = 15,
  parameter int                CNT_W      = 8,
  parameter int                SW         = (NUM_STAGES <= 2) ? 1 : $clog2(NUM_STAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [FLAG_W-1:0] i_flags,
  output logic [2:0]        o_state,
  output logic [SW-1:0]     o_stage,
  output logic              o_match_done,
  output logic              o_error_flag,
  output logic [CNT_W-1:0]  o_hit_count,
  output logic [CNT_W-1:0]  o_fail_count
);

  // wait counter only needs to reach TIMEOUT-1
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_MATCH   = 3'd2,
    S_DEEP    = 3'd3,
    S_UNLOCK  = 3'd4,
    S_FAIL    = 3'd5,
    S_TIMEOUT = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_stage;
  logic [TW-1:0]    r_wait_cnt;
  logic             r_match_done;
  logic             r_error_flag;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_fail_count;
  logic [SW-1:0]    w_stage_inc;

  // key for a stage index, wrapping modulo 2^DATA_W
  function automatic logic [DATA_W-1:0] key_of(input logic [SW-1:0] idx);
    return KEY_BASE + DATA_W'(idx);
  endfunction

  // counter increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign w_stage_inc = r_stage + SW'(1);

  // sequence FSM with registered status outputs and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_stage      <= '0;
      r_wait_cnt   <= '0;
      r_match_done <= 1'b0;
      r_error_flag <= 1'b0;
      r_hit_count  <= '0;
      r_fail_count <= '0;
    end else if (i_clear) begin
      // clear re-arms directly and drops any beat presented this cycle
      r_state      <= S_ARM;
      r_stage      <= '0;
      r_wait_cnt   <= '0;
      r_match_done <= 1'b0;
      r_error_flag <= 1'b0;
      r_hit_count  <= '0;
      r_fail_count <= '0;
    end else begin
      r_match_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_ARM;
          r_stage <= '0;
        end
        S_ARM: begin
          if (i_in_valid) begin
            if (i_data_in == key_of(SW'(0))) begin
              r_stage    <= SW'(1);
              r_wait_cnt <= '0;
              r_state    <= (NUM_STAGES == 2) ? S_DEEP : S_MATCH;
            end else begin
              r_state      <= S_FAIL;
              r_fail_count <= sat_inc(r_fail_count);
            end
          end
        end
        S_MATCH: begin
          if (i_in_valid) begin
            r_wait_cnt <= '0;
            if (i_data_in == key_of(r_stage) && i_flags[0]) begin
              r_stage <= w_stage_inc;
              if (w_stage_inc == SW'(NUM_STAGES - 1)) r_state <= S_DEEP;
            end else begin
              r_state      <= S_FAIL;
              r_fail_count <= sat_inc(r_fail_count);
            end
          end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
            r_state      <= S_TIMEOUT;
            r_fail_count <= sat_inc(r_fail_count);
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end
        S_DEEP: begin
          if (i_in_valid) begin
            r_wait_cnt <= '0;
            if (i_data_in == key_of(SW'(NUM_STAGES - 1)) && (&i_flags)) begin
              r_state      <= S_UNLOCK;
              r_match_done <= 1'b1;
              r_hit_count  <= sat_inc(r_hit_count);
            end else begin
              r_state      <= S_FAIL;
              r_fail_count <= sat_inc(r_fail_count);
            end
          end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
            r_state      <= S_TIMEOUT;
            r_fail_count <= sat_inc(r_fail_count);
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end
        S_UNLOCK: begin
          // a trailing 0xCD in bits 15:8 right after unlock is the trap
          if (i_in_valid && i_data_in[15:8] == 8'hCD) begin
            r_state      <= S_ERROR;
            r_error_flag <= 1'b1;
          end else begin
            r_state <= S_ARM;
            r_stage <= '0;
          end
        end
        S_FAIL, S_TIMEOUT: begin
          r_state <= S_ARM;
          r_stage <= '0;
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          r_state <= S_ARM;
          r_stage <= '0;
        end
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_stage      = r_stage;
  assign o_match_done = r_match_done;
  assign o_error_flag = r_error_flag;
  assign o_hit_count  = r_hit_count;
  assign o_fail_count = r_fail_count;

endmodule

// File: tb/tb_toy_seq_unlock.sv
// Directed testbench for toy_seq_unlock: a default instance, a CNT_W=2
// instance sharing its stimulus, and a NUM_STAGES=2 wrap-key instance.
module tb_toy_seq_unlock;

  localparam logic [2:0] IDLE = 3'd0, ARM = 3'd1, MATCH = 3'd2, DEEP = 3'd3,
                         UNLOCK = 3'd4, FAIL = 3'd5, TOUT = 3'd6, ERR = 3'd7;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [1:0] sg;
    logic       md;
    logic       ef;
    logic [7:0] hc;
    logic [7:0] fc;
    logic [1:0] hc2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for u0 / u1
  logic        rst_a, a_clear, a_valid;
  logic [31:0] a_data;
  logic [3:0]  a_flags;
  logic [2:0]  u0_state, u1_state;
  logic [1:0]  u0_stage, u1_stage;
  logic        u0_md, u0_ef, u1_md, u1_ef;
  logic [7:0]  u0_hc, u0_fc;
  logic [1:0]  u1_hc, u1_fc;

  // stimulus for u2
  logic        rst_b, b_clear, b_valid;
  logic [31:0] b_data;
  logic [3:0]  b_flags;
  logic [2:0]  u2_state;
  logic [0:0]  u2_stage;
  logic        u2_md, u2_ef;
  logic [7:0]  u2_hc, u2_fc;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t q[$];
  exp_t q2[$];
  logic [7:0] e_hit, e_fail, e2_hit, e2_fail;
  logic [1:0] e_hc2;
  logic       e_ef, e2_ef;

  toy_seq_unlock u0 (
    .clk(clk), .reset(rst_a), .i_clear(a_clear), .i_in_valid(a_valid),
    .i_data_in(a_data), .i_flags(a_flags), .o_state(u0_state), .o_stage(u0_stage),
    .o_match_done(u0_md), .o_error_flag(u0_ef), .o_hit_count(u0_hc), .o_fail_count(u0_fc)
  );

  toy_seq_unlock #(.CNT_W(2)) u1 (
    .clk(clk), .reset(rst_a), .i_clear(a_clear), .i_in_valid(a_valid),
    .i_data_in(a_data), .i_flags(a_flags), .o_state(u1_state), .o_stage(u1_stage),
    .o_match_done(u1_md), .o_error_flag(u1_ef), .o_hit_count(u1_hc), .o_fail_count(u1_fc)
  );

  toy_seq_unlock #(.NUM_STAGES(2), .KEY_BASE(32'hFFFF_FFFF)) u2 (
    .clk(clk), .reset(rst_b), .i_clear(b_clear), .i_in_valid(b_valid),
    .i_data_in(b_data), .i_flags(b_flags), .o_state(u2_state), .o_stage(u2_stage),
    .o_match_done(u2_md), .o_error_flag(u2_ef), .o_hit_count(u2_hc), .o_fail_count(u2_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle on u0/u1, queue the expected post-edge outputs, then check
  task automatic step(input string tag, input logic v, input logic [31:0] d,
                      input logic [3:0] f, input logic cl,
                      input logic [2:0] st, input logic [1:0] sg);
    exp_t e;
    a_valid = v; a_data = d; a_flags = f; a_clear = cl;
    if (cl) begin
      e_hit = '0; e_fail = '0; e_hc2 = '0; e_ef = 1'b0;
    end else begin
      if (st == UNLOCK) begin
        if (e_hit != 8'hFF) e_hit = e_hit + 8'd1;
        if (e_hc2 != 2'b11) e_hc2 = e_hc2 + 2'd1;
      end
      if ((st == FAIL || st == TOUT) && e_fail != 8'hFF) e_fail = e_fail + 8'd1;
      if (st == ERR) e_ef = 1'b1;
    end
    e.tag = tag; e.st = st; e.sg = sg; e.md = (st == UNLOCK); e.ef = e_ef;
    e.hc = e_hit; e.fc = e_fail; e.hc2 = e_hc2;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chk({e.tag, "/state"}, 32'(u0_state), 32'(e.st));
    chk({e.tag, "/stage"}, 32'(u0_stage), 32'(e.sg));
    chk({e.tag, "/match_done"}, 32'(u0_md), 32'(e.md));
    chk({e.tag, "/error_flag"}, 32'(u0_ef), 32'(e.ef));
    chk({e.tag, "/hit_count"}, 32'(u0_hc), 32'(e.hc));
    chk({e.tag, "/fail_count"}, 32'(u0_fc), 32'(e.fc));
    chk({e.tag, "/hit_count_w2"}, 32'(u1_hc), 32'(e.hc2));
  endtask

  task automatic step2(input string tag, input logic v, input logic [31:0] d,
                       input logic [3:0] f, input logic [2:0] st, input logic sg);
    exp_t e;
    b_valid = v; b_data = d; b_flags = f;
    if (st == UNLOCK) e2_hit = e2_hit + 8'd1;
    if (st == FAIL || st == TOUT) e2_fail = e2_fail + 8'd1;
    e.tag = tag; e.st = st; e.sg = {1'b0, sg}; e.md = (st == UNLOCK); e.ef = e2_ef;
    e.hc = e2_hit; e.fc = e2_fail; e.hc2 = '0;
    q2.push_back(e);
    @(posedge clk); #1;
    e = q2.pop_front();
    chk({e.tag, "/state"}, 32'(u2_state), 32'(e.st));
    chk({e.tag, "/stage"}, 32'(u2_stage), 32'(e.sg));
    chk({e.tag, "/match_done"}, 32'(u2_md), 32'(e.md));
    chk({e.tag, "/hit_count"}, 32'(u2_hc), 32'(e.hc));
    chk({e.tag, "/fail_count"}, 32'(u2_fc), 32'(e.fc));
  endtask

  task automatic unlock_seq(input string tag);
    step({tag, "_k0"}, 1'b1, 32'hAB, 4'h0, 1'b0, MATCH, 2'd1);
    step({tag, "_k1"}, 1'b1, 32'hAC, 4'h1, 1'b0, MATCH, 2'd2);
    step({tag, "_k2"}, 1'b1, 32'hAD, 4'h1, 1'b0, DEEP, 2'd3);
    step({tag, "_k3"}, 1'b1, 32'hAE, 4'hF, 1'b0, UNLOCK, 2'd3);
  endtask

  initial begin
    rst_a = 1'b1; a_clear = 1'b0; a_valid = 1'b0; a_data = '0; a_flags = '0;
    rst_b = 1'b1; b_clear = 1'b0; b_valid = 1'b0; b_data = '0; b_flags = '0;
    e_hit = '0; e_fail = '0; e_hc2 = '0; e_ef = 1'b0;
    e2_hit = '0; e2_fail = '0; e2_ef = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/state", 32'(u0_state), 32'(IDLE));
    chk("rst/stage", 32'(u0_stage), 32'd0);
    chk("rst/match_done", 32'(u0_md), 32'd0);
    chk("rst/error_flag", 32'(u0_ef), 32'd0);
    chk("rst/hit_count", 32'(u0_hc), 32'd0);
    chk("rst/fail_count", 32'(u0_fc), 32'd0);
    chk("rst/u2_state", 32'(u2_state), 32'(IDLE));
    rst_a = 1'b0; rst_b = 1'b0;
    step("rel", 1'b0, 32'h0, 4'h0, 1'b0, ARM, 2'd0);
    step("arm_idle", 1'b0, 32'hAB, 4'h0, 1'b0, ARM, 2'd0);

    // full unlock, then back to ARM
    unlock_seq("t1");
    step("t1_back", 1'b0, 32'h0, 4'h0, 1'b0, ARM, 2'd0);

    // flag[0] missing on third beat
    step("t2_k0", 1'b1, 32'hAB, 4'h0, 1'b0, MATCH, 2'd1);
    step("t2_k1", 1'b1, 32'hAC, 4'h1, 1'b0, MATCH, 2'd2);
    step("t2_bad", 1'b1, 32'hAD, 4'h0, 1'b0, FAIL, 2'd2);
    step("t2_back", 1'b0, 32'h0, 4'h0, 1'b0, ARM, 2'd0);

    // wrong first word, and wrong key in MATCH
    step("t2_w0", 1'b1, 32'h12, 4'hF, 1'b0, FAIL, 2'd0);
    step("t2_w0b", 1'b0, 32'h0, 4'h0, 1'b0, ARM, 2'd0);
    step("t2_m0", 1'b1, 32'hAB, 4'h0, 1'b0, MATCH, 2'd1);
    step("t2_m1", 1'b1, 32'hAD, 4'h1, 1'b0, FAIL, 2'd1);
    step("t2_m1b", 1'b0, 32'h0, 4'h0, 1'b0, ARM, 2'd0);

    // DEEP needs all flag bits
    step("t2_d0", 1'b1, 32'hAB, 4'h0, 1'b0, MATCH, 2'd1);
    step("t2_d1", 1'b1, 32'hAC, 4'h1, 1'b0, MATCH, 2'd2);
    step("t2_d2", 1'b1, 32'hAD, 4'h1, 1'b0, DEEP, 2'd3);
    step("t2_d3", 1'b1, 32'hAE, 4'h7, 1'b0, FAIL, 2'd3);
    step("t2_d3b", 1'b0, 32'h0, 4'h0, 1'b0, ARM, 2'd0);

    // timeout in MATCH after 15 idle cycles
    step("t3_k0", 1'b1, 32'hAB, 4'h0, 1'b0, MATCH, 2'd1);
    for (int i = 0; i < 14; i++) step("t3_idle", 1'b0, 32'h0, 4'h0, 1'b0, MATCH, 2'd1);
    step("t3_to", 1'b0, 32'h0, 4'h0, 1'b0, TOUT, 2'd1);
    step("t3_back", 1'b0, 32'h0, 4'h0, 1'b0, ARM, 2'd0);

    // 14 idle cycles survive; then DEEP times out
    step("t3b_k0", 1'b1, 32'hAB, 4'h0, 1'b0, MATCH, 2'd1);
    step("t3b_k1", 1'b1, 32'hAC, 4'h1, 1'b0, MATCH, 2'd2);
    for (int i = 0; i < 14; i++) step("t3b_idle", 1'b0, 32'h0, 4'h0, 1'b0, MATCH, 2'd2);
    step("t3b_k2", 1'b1, 32'hAD, 4'h1, 1'b0, DEEP, 2'd3);
    for (int i = 0; i < 14; i++) step("t3b_didle", 1'b0, 32'h0, 4'h0, 1'b0, DEEP, 2'd3);
    step("t3b_to", 1'b0, 32'h0, 4'h0, 1'b0, TOUT, 2'd3);
    step("t3b_back", 1'b0, 32'h0, 4'h0, 1'b0, ARM, 2'd0);

    // UNLOCK beat with 0xCD in the wrong byte does not trap
    unlock_seq("t4a");
    step("t4a_lowcd", 1'b1, 32'h0000_00CD, 4'h0, 1'b0, ARM, 2'd0);

    // trap into ERROR, hold, then clear (beat in clear cycle discarded)
    unlock_seq("t4");
    step("t4_err", 1'b1, 32'h0000_CD00, 4'h0, 1'b0, ERR, 2'd3);
    for (int i = 0; i < 50; i++)
      step("t4_hold", 1'($urandom), $urandom, 4'($urandom), 1'b0, ERR, 2'd3);
    step("t4_clr", 1'b1, 32'hAB, 4'h0, 1'b1, ARM, 2'd0);
    step("t4_post", 1'b0, 32'h0, 4'h0, 1'b0, ARM, 2'd0);

    // five unlocks: 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      unlock_seq("t5");
      step("t5_back", 1'b0, 32'h0, 4'h0, 1'b0, ARM, 2'd0);
    end

    // two-stage instance with wrapping key
    step2("t6_arm", 1'b0, 32'h0, 4'h0, ARM, 1'b0);
    step2("t6_k0", 1'b1, 32'hFFFF_FFFF, 4'h0, DEEP, 1'b1);
    step2("t6_k1", 1'b1, 32'h0000_0000, 4'hF, UNLOCK, 1'b1);
    step2("t6_back", 1'b0, 32'h0, 4'h0, ARM, 1'b0);
    step2("t6_f0", 1'b1, 32'hFFFF_FFFF, 4'h0, DEEP, 1'b1);
    step2("t6_f1", 1'b1, 32'h0000_0000, 4'h7, FAIL, 1'b1);
    step2("t6_fb", 1'b0, 32'h0, 4'h0, ARM, 1'b0);
    step2("t6_r0", 1'b1, 32'hFFFF_FFFF, 4'h0, DEEP, 1'b1);
    b_valid = 1'b0;
    rst_b = 1'b1;
    #2;
    chk("t6_rst/state", 32'(u2_state), 32'(IDLE));
    chk("t6_rst/stage", 32'(u2_stage), 32'd0);
    chk("t6_rst/hit_count", 32'(u2_hc), 32'd0);
    chk("t6_rst/fail_count", 32'(u2_fc), 32'd0);
    e2_hit = '0; e2_fail = '0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    step2("t6_rel", 1'b0, 32'h0, 4'h0, ARM, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
